// File: rtl/multiply_shift_add_if.sv
// Handshake/operand bundle between the two's-complement stage and the shift-add multiplier.
// The ovf flag exists only when MULT_RANGE_FLAG_EN is defined.
interface multiply_shift_add_if;
  logic       start;
  logic [3:0] first_nr;
  logic [3:0] second_nr;
  logic       sign_first;
  logic       sign_second;
  logic [7:0] product;
  logic       busy;
  logic       done;
`ifdef MULT_RANGE_FLAG_EN
  logic       ovf;

  modport master (
    output start, first_nr, second_nr, sign_first, sign_second,
    input  product, busy, done, ovf
  );
  modport slave (
    input  start, first_nr, second_nr, sign_first, sign_second,
    output product, busy, done, ovf
  );
`else
  modport master (
    output start, first_nr, second_nr, sign_first, sign_second,
    input  product, busy, done
  );
  modport slave (
    input  start, first_nr, second_nr, sign_first, sign_second,
    output product, busy, done
  );
`endif
endinterface

// File: rtl/multiply_shift_add.sv
// Sequential 4-bit sign-magnitude shift-and-add multiplier: accept, 4 RUN edges, SIGN edge, done pulse.
// Optional MULT_RANGE_FLAG_EN adds ovf, set when the signed result does not fit -8..+7.
module multiply_shift_add (
  input  logic                 clk,
  input  logic                 rst,
  multiply_shift_add_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SIGN} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_acc;
  logic [7:0] r_mcand;
  logic [3:0] r_mplier;
  logic [1:0] r_cnt;
  logic       r_neg;
  logic [7:0] r_product;
  logic       r_done;
  logic       w_load;
  logic       w_step;
  logic       w_finish;
  logic       w_is_neg;
  logic [7:0] w_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == 2'd3) w_state_nxt = S_SIGN;
      S_SIGN:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_load   = 1'b0;
    w_step   = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      S_IDLE:  w_load   = bus.start;
      S_RUN:   w_step   = 1'b1;
      S_SIGN:  w_finish = 1'b1;
      default: ;
    endcase
  end

  // A zero magnitude is never reported as negative.
  assign w_is_neg = r_neg && (r_acc != 8'd0);
  assign w_result = w_is_neg ? (8'd0 - r_acc) : r_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc     <= 8'd0;
      r_mcand   <= 8'd0;
      r_mplier  <= 4'd0;
      r_cnt     <= 2'd0;
      r_neg     <= 1'b0;
      r_product <= 8'd0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_load) begin
        r_mcand  <= {4'b0, bus.first_nr};
        r_mplier <= bus.second_nr;
        r_acc    <= 8'd0;
        r_cnt    <= 2'd0;
        r_neg    <= bus.sign_first ^ bus.sign_second;
      end else if (w_step) begin
        if (r_mplier[0]) r_acc <= r_acc + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 2'd1;
      end
      if (w_finish) r_product <= w_result;
    end
  end

  assign bus.product = r_product;
  assign bus.done    = r_done;
  assign bus.busy    = (r_state != S_IDLE);

`ifdef MULT_RANGE_FLAG_EN
  logic r_ovf;

  // Negative results reach -8 in 4 bits, positive ones only +7.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_ovf <= 1'b0;
    else if (w_finish) r_ovf <= w_is_neg ? (r_acc > 8'd8) : (r_acc > 8'd7);
  end

  assign bus.ovf = r_ovf;
`endif
endmodule

// File: doc/multiply_shift_add.md
# multiply_shift_add

Sequential 4-bit sign-magnitude multiplier for the calculator multiply path. Sits directly downstream of the two's-complement stage. That stage delivers operand magnitudes; this block multiplies them by shift-and-add over several clock cycles. It then applies the result sign and presents a signed 8-bit product with a start/done handshake.

## Interface
- No parameters; widths fixed (4-bit operands, 8-bit product).
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- first_nr  input  4  multiplicand magnitude, unsigned 0..8 (4'b1000 = 8).
- second_nr  input  4  multiplier magnitude, unsigned 0..8.
- sign_first  input  1  1 = first operand negative.
- sign_second  input  1  1 = second operand negative.
- product  output  8  signed two's-complement result, held until next completion.
- busy  output  1  high from the accepting edge until the edge that raises done.
- done  output  1  one-cycle completion pulse.
- ovf  output  1  present only with MULT_RANGE_FLAG_EN; see Configuration.

## Operation
- States: IDLE, RUN, SIGN.
- IDLE, start=1 at a rising edge:
  - mcand <= {4'b0, first_nr}
  - mplier <= second_nr
  - acc <= 0, cnt <= 0
  - neg <= sign_first ^ sign_second
  - busy <= 1; go to RUN
- RUN, each edge:
  - If mplier[0], acc <= acc + mcand (8-bit, no overflow possible; max 64).
  - mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt + 1.
  - Go to SIGN after the 4th RUN edge (cnt == 3 before increment).
- SIGN, one edge:
  - product <= (neg && acc != 0) ? -acc : acc. Zero is never negative.
  - done <= 1; busy <= 0; go to IDLE.
- done clears on the following edge.
- start while busy or in SIGN: ignored, not queued.
- start held high across completion: a new operation is accepted on the first IDLE edge, i.e. the edge after done rises.
- Operand inputs are sampled only on the accepting edge; later changes are ignored.
- Product range -64..+64; 8 x 8 = 64, -8 x 8 = 8'hC0.

## Timing
- Reset values: product = 8'h00, busy = 0, done = 0, ovf = 0. Internal state = IDLE; acc, mcand, mplier, cnt = 0.
- Reset asserted mid-operation aborts immediately (asynchronous). No done is produced for the aborted request.
- Latency, fixed mode: accept edge E0; RUN edges E1..E4; SIGN edge E5.
  - done and product valid after E5; done low after E6.
  - Back-to-back throughput: one result per 6 cycles.
- busy is high after E0 through E4 and low after E5.

## Configuration
- MULT_RANGE_FLAG_EN
  - Defined:
    - ovf output exists.
    - At the SIGN edge, ovf <= 1 if the signed result lies outside -8..+7, i.e. it does not fit the 4-bit display/result format; otherwise ovf <= 0.
    - ovf is held with product and cleared by reset only.
  - Undefined:
    - ovf port and its logic are absent.
    - All other behaviour and latency are identical.

## Test plan
- Reset check: rst pulse, no start -> product=8'h00, busy=0, done=0 for 10 cycles.
- Basic: first_nr=3, second_nr=5, signs 0/0, start 1 cycle -> done exactly 5 cycles after the accept edge, product=8'h0F, busy high for 5 cycles.
- Signs:
  - 7 x 7 with sign_first=1 -> product=8'hCF (-49).
  - 8 x 8 with both signs 1 -> product=8'h40 (+64).
- Zero sign: 0 x 6, sign_first=1 -> product=8'h00, no negative zero. With MULT_RANGE_FLAG_EN, ovf=0.
- Busy handling:
  - start re-pulsed during RUN -> ignored, single done.
  - start held high -> second accept on the edge after done rises.
  - Operands changed mid-RUN -> result uses the originally sampled values.
- Abort: rst asserted at RUN edge E2 -> outputs return to reset values immediately, no done. The next start (2 x 3) -> product=8'h06.
- With MULT_RANGE_FLAG_EN: 2 x 3 -> ovf=0; 3 x 3 -> ovf=1; -2 x 4 -> ovf=0; -3 x 3 -> ovf=1.
